// File: rtl/hart_sched_pkg.sv
// Shared types and helpers for the coarse-grained multithreading scheduler.
//   hart_status_t : per-hart run status (READY / WAITING / DONE)
//   sched_state_t : scheduler FSM state (RUN / SWITCH / IDLE / HALT)
//   hart_w()      : width of a hart index, never below one bit
package hart_sched_pkg;

  typedef enum logic [1:0] {
    HS_READY   = 2'd0,
    HS_WAITING = 2'd1,
    HS_DONE    = 2'd2
  } hart_status_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SWITCH = 2'd1,
    ST_IDLE   = 2'd2,
    ST_HALT   = 2'd3
  } sched_state_t;

  function automatic int unsigned hart_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hart_scheduler_picker.sv
// rr_hart_picker: combinational round-robin search for a READY hart.
//   status_i : per-hart status vector
//   start_i  : first hart index to examine; the search wraps, so the hart
//              just before start_i is examined last
//   found_o  : some hart is READY
//   pick_o   : first READY hart in search order (0 when none found)
module rr_hart_picker
  import hart_sched_pkg::*;
#(
  parameter int unsigned NUM_HARTS = 4,
  parameter int unsigned HART_W    = hart_w(NUM_HARTS)
) (
  input  hart_status_t [NUM_HARTS-1:0] status_i,
  input  logic [HART_W-1:0]            start_i,
  output logic                         found_o,
  output logic [HART_W-1:0]            pick_o
);

  logic [NUM_HARTS-1:0]   ready;
  logic [2*NUM_HARTS-1:0] ready_x2;
  logic [NUM_HARTS-1:0]   rot;
  logic [HART_W:0]        sum;

  // Doubling the ready vector turns the wrapping search into a plain
  // lowest-set-bit scan of a rotated copy.
  always_comb begin
    ready = '0;
    for (int unsigned i = 0; i < NUM_HARTS; i++) begin
      ready[i] = (status_i[i] == HS_READY);
    end
    ready_x2 = {ready, ready};
    rot      = NUM_HARTS'(ready_x2 >> start_i);
    found_o  = 1'b0;
    pick_o   = '0;
    sum      = '0;
    for (int unsigned k = 0; k < NUM_HARTS; k++) begin
      if (!found_o && rot[k]) begin
        found_o = 1'b1;
        sum     = {1'b0, start_i} + (HART_W+1)'(k);
        if (sum >= (HART_W+1)'(NUM_HARTS)) begin
          pick_o = HART_W'(sum - (HART_W+1)'(NUM_HARTS));
        end else begin
          pick_o = sum[HART_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/hart_scheduler.sv
// hart_scheduler: coarse-grained multithreading scheduler.
// Tracks READY/WAITING/DONE per hart, switches the pipeline to another
// READY hart on a cache miss or thread termination, wakes harts when their
// fill completes, idles when nothing is runnable and halts once every hart
// is DONE. All outputs are registered.
//   CLK, nRST          : clock, asynchronous active-low reset
//   cache_miss         : active hart stalled on a miss (pulse)
//   thread_terminated  : active hart terminated (pulse, beats cache_miss)
//   cache_updated      : fill done for hart fill_hart_id (pulse)
//   fill_hart_id       : hart owning the completed fill
//   active_hart        : hart owning the pipeline
//   switch_req         : one-cycle flush/context-swap strobe
//   idle               : no hart ready, pipeline stalls
//   halt_proc          : all harts terminated
// Optional feature: define HART_PREEMPT_EN for TIMESLICE-cycle preemption.
module hart_scheduler
  import hart_sched_pkg::*;
#(
  parameter  int unsigned NUM_HARTS = 4,
  parameter  int unsigned TIMESLICE = 256,
  localparam int unsigned HART_W    = hart_w(NUM_HARTS)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              cache_miss,
  input  logic              thread_terminated,
  input  logic              cache_updated,
  input  logic [HART_W-1:0] fill_hart_id,
  output logic [HART_W-1:0] active_hart,
  output logic              switch_req,
  output logic              idle,
  output logic              halt_proc
);

  if (NUM_HARTS < 2) begin : g_chk_harts
    $error("hart_scheduler needs at least two harts");
  end
  if (TIMESLICE < 2) begin : g_chk_slice
    $error("hart_scheduler TIMESLICE must be at least 2");
  end

  hart_status_t [NUM_HARTS-1:0] status_q, status_d;
  sched_state_t                 state_q;
  logic [HART_W-1:0]            active_q, start, pick;
  logic                         switch_q, idle_q, halt_q;
  logic                         found, run_event, any_waiting, fill_valid;

`ifdef HART_PREEMPT_EN
  localparam int unsigned CNT_W = $clog2(TIMESLICE);
  logic [CNT_W-1:0] cnt_q;
  logic             expire_q;
`endif

  assign fill_valid = (32'(fill_hart_id) < NUM_HARTS);
  assign run_event  = (state_q == ST_RUN) && (thread_terminated || cache_miss);
  assign start      = (32'(active_q) == NUM_HARTS - 1) ? '0 : active_q + HART_W'(1);

  // Wake is applied before the run event so a same-cycle fill is visible
  // to the picker; the outgoing hart's new status is folded in as well.
  always_comb begin
    status_d = status_q;
    if (cache_updated && fill_valid && status_q[fill_hart_id] == HS_WAITING) begin
      status_d[fill_hart_id] = HS_READY;
    end
    if (state_q == ST_RUN) begin
      if (thread_terminated) begin
        status_d[active_q] = HS_DONE;
      end else if (cache_miss) begin
        status_d[active_q] = HS_WAITING;
      end
    end
  end

  always_comb begin
    any_waiting = 1'b0;
    for (int unsigned i = 0; i < NUM_HARTS; i++) begin
      if (status_d[i] == HS_WAITING) any_waiting = 1'b1;
    end
  end

  rr_hart_picker #(
    .NUM_HARTS (NUM_HARTS),
    .HART_W    (HART_W)
  ) u_picker (
    .status_i (status_d),
    .start_i  (start),
    .found_o  (found),
    .pick_o   (pick)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ST_RUN;
      for (int unsigned i = 0; i < NUM_HARTS; i++) status_q[i] <= HS_READY;
      active_q <= '0;
      switch_q <= 1'b0;
      idle_q   <= 1'b0;
      halt_q   <= 1'b0;
`ifdef HART_PREEMPT_EN
      cnt_q    <= '0;
      expire_q <= 1'b0;
`endif
    end else begin
      status_q <= status_d;
      switch_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (run_event) begin
            if (found) begin
              state_q  <= ST_SWITCH;
              active_q <= pick;
              switch_q <= 1'b1;
            end else if (any_waiting) begin
              state_q <= ST_IDLE;
              idle_q  <= 1'b1;
            end else begin
              state_q <= ST_HALT;
              halt_q  <= 1'b1;
            end
`ifdef HART_PREEMPT_EN
            cnt_q    <= '0;
            expire_q <= 1'b0;
          end else if (expire_q) begin
            // Expiry is registered, so the decision lands one cycle after
            // the count reaches TIMESLICE-1; the current hart is searched
            // last, so pick == active_q means nobody else is READY.
            cnt_q    <= '0;
            expire_q <= 1'b0;
            if (found && pick != active_q) begin
              state_q  <= ST_SWITCH;
              active_q <= pick;
              switch_q <= 1'b1;
            end
          end else if (cnt_q == CNT_W'(TIMESLICE - 1)) begin
            expire_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
`endif
          end
        end
        ST_SWITCH: begin
          state_q <= ST_RUN;
`ifdef HART_PREEMPT_EN
          cnt_q    <= '0;
          expire_q <= 1'b0;
`endif
        end
        ST_IDLE: begin
          if (found) begin
            state_q  <= ST_SWITCH;
            active_q <= pick;
            switch_q <= 1'b1;
            idle_q   <= 1'b0;
          end
        end
        ST_HALT: begin
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign active_hart = active_q;
  assign switch_req  = switch_q;
  assign idle        = idle_q;
  assign halt_proc   = halt_q;

endmodule

// File: tb/tb_hart_scheduler.sv
module tb_hart_scheduler;

  localparam int N  = 4;
  localparam int TS = 8;

  localparam int RDY = 0, WT = 1, DN = 2;
  localparam int M_RUN = 0, M_SW = 1, M_IDLE = 2, M_HALT = 3;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       cache_miss = 1'b0;
  logic       thread_terminated = 1'b0;
  logic       cache_updated = 1'b0;
  logic [1:0] fill_hart_id = 2'd0;
  logic [1:0] active_hart;
  logic       switch_req, idle, halt_proc;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  hart_scheduler #(
    .NUM_HARTS (N),
    .TIMESLICE (TS)
  ) dut (
    .CLK               (CLK),
    .nRST              (nRST),
    .cache_miss        (cache_miss),
    .thread_terminated (thread_terminated),
    .cache_updated     (cache_updated),
    .fill_hart_id      (fill_hart_id),
    .active_hart       (active_hart),
    .switch_req        (switch_req),
    .idle              (idle),
    .halt_proc         (halt_proc)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  typedef struct {
    int st[4];
    int mode;
    int hart;
    int rl;     // RUN cycles completed in the current stint
  } mstate_t;

  mstate_t m;

  function automatic mstate_t reset_state();
    mstate_t r;
    for (int i = 0; i < N; i++) r.st[i] = RDY;
    r.mode = M_RUN;
    r.hart = 0;
    r.rl   = 0;
    return r;
  endfunction

  // First READY hart among (h+1 .. h+span) mod N, or -1.
  function automatic int first_ready(input int s[4], input int h, input int span);
    for (int k = 1; k <= span; k++) begin
      if (s[(h + k) % N] == RDY) return (h + k) % N;
    end
    return -1;
  endfunction

  function automatic mstate_t step(input mstate_t cur, input logic miss, input logic term,
                                   input logic upd, input logic [1:0] fid);
    mstate_t nx;
    int c;
    bit ev;
    bit anyw;
    nx = cur;
    ev = 1'b0;
    if (upd && nx.st[fid] == WT) nx.st[fid] = RDY;
    case (cur.mode)
      M_RUN: begin
        if (term) begin
          nx.st[cur.hart] = DN; ev = 1'b1;
        end else if (miss) begin
          nx.st[cur.hart] = WT; ev = 1'b1;
        end
        if (ev) begin
          c = first_ready(nx.st, cur.hart, N);
          anyw = 1'b0;
          for (int i = 0; i < N; i++) if (nx.st[i] == WT) anyw = 1'b1;
          if (c >= 0) begin
            nx.mode = M_SW; nx.hart = c;
          end else if (anyw) begin
            nx.mode = M_IDLE;
          end else begin
            nx.mode = M_HALT;
          end
          nx.rl = 0;
        end
`ifdef HART_PREEMPT_EN
        else if (cur.rl == TS) begin
          c = first_ready(nx.st, cur.hart, N - 1);
          if (c >= 0) begin
            nx.mode = M_SW; nx.hart = c;
          end
          nx.rl = 0;
        end else begin
          nx.rl = cur.rl + 1;
        end
`endif
      end
      M_SW: begin
        nx.mode = M_RUN;
        nx.rl   = 0;
      end
      M_IDLE: begin
        c = first_ready(nx.st, cur.hart, N);
        if (c >= 0) begin
          nx.mode = M_SW; nx.hart = c;
        end
      end
      default: ;
    endcase
    return nx;
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) m <= reset_state();
    else       m <= step(m, cache_miss, thread_terminated, cache_updated, fill_hart_id);
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("active_hart", int'(active_hart), m.hart);
      check("switch_req",  int'(switch_req),  int'(m.mode == M_SW));
      check("idle",        int'(idle),        int'(m.mode == M_IDLE));
      check("halt_proc",   int'(halt_proc),   int'(m.mode == M_HALT));
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse(input logic miss, input logic term, input logic upd, input logic [1:0] fid);
    cache_miss = miss; thread_terminated = term; cache_updated = upd; fill_hart_id = fid;
    @(negedge CLK);
    cache_miss = 1'b0; thread_terminated = 1'b0; cache_updated = 1'b0; fill_hart_id = 2'd0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2 nRST = 1'b0;
    repeat (2) @(negedge CLK);
    #2 nRST = 1'b1;
  endtask

  initial begin
    @(posedge CLK);
    #1 chk_en = 1'b1;
    check("reset_active", int'(active_hart), 0);
    check("reset_switch", int'(switch_req), 0);
    check("reset_idle",   int'(idle), 0);
    check("reset_halt",   int'(halt_proc), 0);
    @(negedge CLK);
    #2 nRST = 1'b1;

    // Miss on hart 0, then a miss during SWITCH that must be ignored.
    pulse(1'b1, 1'b0, 1'b0, 2'd0);
`ifndef HART_PREEMPT_EN
    check("miss_active", int'(active_hart), 1);
    check("miss_switch", int'(switch_req), 1);
    check("model_h0_waiting", m.st[0], WT);
`endif
    pulse(1'b1, 1'b0, 1'b0, 2'd0);
`ifndef HART_PREEMPT_EN
    check("switch_ignore_active", int'(active_hart), 1);
    check("switch_ignore_sw", int'(switch_req), 0);
    check("model_h1_ready", m.st[1], RDY);
`endif
    // Terminate harts 1..3 with hart 0 still waiting -> IDLE.
    pulse(1'b0, 1'b1, 1'b0, 2'd0);
    cyc(1);
    pulse(1'b0, 1'b1, 1'b0, 2'd0);
    cyc(1);
    pulse(1'b0, 1'b1, 1'b0, 2'd0);
`ifndef HART_PREEMPT_EN
    check("idle_set", int'(idle), 1);
    check("idle_active", int'(active_hart), 3);
`endif
    cyc(2);
    pulse(1'b0, 1'b0, 1'b1, 2'd2);   // fill for a DONE hart: no effect
`ifndef HART_PREEMPT_EN
    check("fill_done_ignored", int'(idle), 1);
`endif
    pulse(1'b0, 1'b0, 1'b1, 2'd0);
`ifndef HART_PREEMPT_EN
    check("wake_active", int'(active_hart), 0);
    check("wake_switch", int'(switch_req), 1);
    check("wake_idle", int'(idle), 0);
`endif
    cyc(3);

    // Terminate + miss together on hart 2 -> DONE, pick 3.
    do_reset();
    pulse(1'b1, 1'b0, 1'b0, 2'd0);
    cyc(1);
    pulse(1'b1, 1'b0, 1'b0, 2'd0);
    cyc(1);
    pulse(1'b1, 1'b1, 1'b0, 2'd0);
`ifndef HART_PREEMPT_EN
    check("term_wins_active", int'(active_hart), 3);
    check("model_h2_done", m.st[2], DN);
`endif
    cyc(1);
    // Wake hart 1 while hart 3 runs, then terminate hart 3 -> pick 1.
    pulse(1'b0, 1'b0, 1'b1, 2'd1);
    pulse(1'b0, 1'b1, 1'b0, 2'd0);
`ifndef HART_PREEMPT_EN
    check("after_wake_pick", int'(active_hart), 1);
`endif
    cyc(1);
    // Hart 1 misses while hart 0 wakes the same cycle -> bypass, wrap to 0.
    pulse(1'b1, 1'b0, 1'b1, 2'd0);
`ifndef HART_PREEMPT_EN
    check("bypass_active", int'(active_hart), 0);
    check("bypass_switch", int'(switch_req), 1);
`endif
    cyc(3);

    // Terminate all four harts in sequence -> HALT.
    do_reset();
    pulse(1'b0, 1'b1, 1'b0, 2'd0);
    cyc(1);
    pulse(1'b0, 1'b1, 1'b0, 2'd0);
    cyc(1);
    pulse(1'b0, 1'b1, 1'b0, 2'd0);
`ifndef HART_PREEMPT_EN
    check("seq_active3", int'(active_hart), 3);
`endif
    cyc(1);
    pulse(1'b0, 1'b1, 1'b0, 2'd0);
`ifndef HART_PREEMPT_EN
    check("halt_set", int'(halt_proc), 1);
    check("halt_active_hold", int'(active_hart), 3);
`endif
    cyc(2);
    pulse(1'b0, 1'b0, 1'b1, 2'd0);
    pulse(1'b1, 1'b1, 1'b0, 2'd0);
`ifndef HART_PREEMPT_EN
    check("halt_sticky", int'(halt_proc), 1);
`endif
    #2 nRST = 1'b0;
    #1;
    check("halt_reset_active", int'(active_hart), 0);
    check("halt_reset_halt", int'(halt_proc), 0);
    cyc(2);
    #2 nRST = 1'b1;
    cyc(2);

`ifdef HART_PREEMPT_EN
    begin
      int t_prev;
      int np;
      int picks_exp[5];
      picks_exp = '{1, 2, 3, 0, 1};
      t_prev = -1;
      np = 0;
      do_reset();
      for (int c = 0; c < 80 && np < 5; c++) begin
        @(negedge CLK);
        if (switch_req) begin
          check("preempt_pick", int'(active_hart), picks_exp[np]);
          if (np > 0) check("preempt_period", c - t_prev, 10);
          t_prev = c;
          np++;
        end
      end
      check("preempt_pulses", np, 5);
    end
`endif

    cyc(2);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
